joy_cursor_accel: RTL and testbench
===================================

// Module: joy_cursor_accel
// PURPOSE
//  Parametrised joystick-to-cursor position engine for the VGA game screen. Converts
//  raw ADC joystick samples into a bounded (x,y) cursor position on each rising edge
//  of a slow cursor tick. Adds over the fixed-step updater: internal tick edge detect,
//  hold-to-accelerate FSM, exact clamping to the play window and a recenter request.
//  Sits between the joystick SPI/ADC front end and the VGA sprite/drawing logic.
// PARAMETERS
//  POS_W      10   width of dot_x/dot_y (pixel coordinates)
//  ADC_W      10   width of joy_x/joy_y samples (0..2^ADC_W-1, centre ~512)
//  INIT_X     234  dot_x after reset/recenter
//  INIT_Y     271  dot_y after reset/recenter
//  X_MIN/X_MAX 239/362  inclusive x window; Y_MIN/Y_MAX 116/426 inclusive y window
//  LO_FAR/LO_NEAR 150/400  sample < LO_FAR -> far step, < LO_NEAR -> near step
//  HI_NEAR/HI_FAR 600/850  sample > HI_FAR -> far step, > HI_NEAR -> near step
//  STEP_NEAR  10   near step (pixels);  STEP_FAR  20  far step (pixels)
//  HOLD_TICKS 8    consecutive active ticks before FAST (steps doubled)
// PORTS
//  clk      in   1      system clock (pixel-domain)
//  clr      in   1      asynchronous active-high reset
//  tick     in   1      slow cursor clock (level); update on its rising edge
//  joy_x    in   ADC_W  horizontal sample; low = move right (+x), high = left (-x)
//  joy_y    in   ADC_W  vertical sample; low = move up (-y), high = down (+y)
//  recenter in   1      synchronous request: force dot to INIT_X/INIT_Y
//  dot_x    out  POS_W  registered cursor x
//  dot_y    out  POS_W  registered cursor y
//  fast     out  1      registered, 1 while FSM in FAST
// BEHAVIOUR
//  Reset (clr=1): dot_x=INIT_X, dot_y=INIT_Y, fast=0, FSM=IDLE, hold count=0, tick_q=1.
//  tick_q<=tick every clk; update event ev = tick & ~tick_q (tick_q reset to 1, so a
//   tick already high when clr releases is NOT an event). Outputs update on the same
//   clk edge that samples ev=1 (visible next cycle); no other clk changes dot_x/dot_y.
//  Per axis per event: magnitude STEP_FAR / STEP_NEAR / 0 from thresholds above
//   (strict compares; LO_NEAR..HI_NEAR inclusive = deadzone); sign per port table.
//  FSM (one shared, advanced only on ev): IDLE: both axes deadzone. SLOW: any axis
//   active, count<HOLD_TICKS. FAST: count reached HOLD_TICKS.
//   - ev with both axes in deadzone -> IDLE, count=0.
//   - ev with activity: count increments (saturates at HOLD_TICKS); when it reaches
//     HOLD_TICKS -> FAST. That tick still uses 1x step; later ticks in FAST use 2x.
//   - sign reversal on either active axis vs previous ev -> SLOW, count=1, 1x step.
//  Arithmetic: new = cur +/- step in signed POS_W+2 bits (no wrap through 0).
//   Default: clamp; new<MIN -> MIN, new>MAX -> MAX. Position already at bound and
//   pushed outward stays at bound. Axes independent.
//  recenter=1: dot<=INIT on that clk, FSM=IDLE, count=0; overrides a coincident ev.
//  clr mid-operation: immediate async return to reset values.
// CONFIGURATION
//  CURSOR_WRAP_EN defined: out-of-window result wraps to the opposite bound
//   (new<MIN -> MAX, new>MAX -> MIN) instead of clamping; a cursor exactly at a bound
//   pushed outward also wraps. Undefined: clamp as above. All else identical.
// TESTING
//  1 clr pulse, tick held high -> dot=(234,271), fast=0; no move until tick falls/rises.
//  2 joy_x=100, joy_y=512, one tick edge -> dot_x=254, dot_y=271; joy=512/512 -> no change.
//  3 dot_x=355, joy_x=100, tick -> dot_x=362 (clamp); again -> 362. With
//    CURSOR_WRAP_EN: 355 -> 239.
//  4 joy_y=700 for 9 ticks from 271 -> 281..351 over ticks 1-8, fast=1 after tick 8,
//    tick 9 -> 371; joy_y=300 next tick -> 361, fast=0.
//  5 recenter asserted on same clk as tick edge with joy_x=100 -> dot=(234,271), IDLE.
//  6 clr asserted mid-FAST between clk edges -> outputs reset immediately, fast=0.

Source files
------------

// File: rtl/joy_cursor_accel.sv
// joy_cursor_accel
//   Joystick-to-cursor position engine for the VGA game screen. Raw ADC
//   joystick samples are turned into a bounded (dot_x, dot_y) cursor position
//   on each rising edge of the slow cursor tick. Holding a direction for
//   HOLD_TICKS consecutive ticks enters FAST, where steps are doubled.
//
//   Configuration macro:
//     CURSOR_WRAP_EN  defined   -> a result outside the window wraps to the
//                                  opposite bound
//                     undefined -> a result outside the window clamps to the
//                                  nearest bound (default build)
//
//   Reset clr is asynchronous and active-high.

module joy_cursor_accel #(
  parameter int POS_W      = 10,
  parameter int ADC_W      = 10,
  parameter int INIT_X     = 234,
  parameter int INIT_Y     = 271,
  parameter int X_MIN      = 239,
  parameter int X_MAX      = 362,
  parameter int Y_MIN      = 116,
  parameter int Y_MAX      = 426,
  parameter int LO_FAR     = 150,
  parameter int LO_NEAR    = 400,
  parameter int HI_NEAR    = 600,
  parameter int HI_FAR     = 850,
  parameter int STEP_NEAR  = 10,
  parameter int STEP_FAR   = 20,
  parameter int HOLD_TICKS = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick,
  input  logic [ADC_W-1:0] joy_x,
  input  logic [ADC_W-1:0] joy_y,
  input  logic             recenter,
  output logic [POS_W-1:0] dot_x,
  output logic [POS_W-1:0] dot_y,
  output logic             fast
);

  // Two extra bits give headroom so cur +/- step never wraps through zero.
  localparam int SW    = POS_W + 2;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);

  localparam logic [ADC_W-1:0] LO_FAR_V  = ADC_W'(LO_FAR);
  localparam logic [ADC_W-1:0] LO_NEAR_V = ADC_W'(LO_NEAR);
  localparam logic [ADC_W-1:0] HI_NEAR_V = ADC_W'(HI_NEAR);
  localparam logic [ADC_W-1:0] HI_FAR_V  = ADC_W'(HI_FAR);

  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOW,
    ST_FAST
  } state_t;

  // Which side of the deadzone a sample sits on. Reversal detection compares
  // sides, so the per-axis sign convention does not matter there.
  typedef enum logic [1:0] {
    SIDE_NONE,
    SIDE_LOW,
    SIDE_HIGH
  } side_t;

  // ---------------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------------
  function automatic side_t side_of(input logic [ADC_W-1:0] s);
    side_t r;
    if (s < LO_NEAR_V)      r = SIDE_LOW;
    else if (s > HI_NEAR_V) r = SIDE_HIGH;
    else                    r = SIDE_NONE;
    return r;
  endfunction

  function automatic logic is_far(input logic [ADC_W-1:0] s);
    return (s < LO_FAR_V) || (s > HI_FAR_V);
  endfunction

  // One axis update: apply the signed step, then bound the result to the
  // window. An axis sitting in the deadzone is left exactly where it is, even
  // if it currently lies outside the window (INIT_X does).
  function automatic logic [POS_W-1:0] move_axis(
    input logic [POS_W-1:0] cur,
    input side_t            side,
    input logic             far,
    input logic             dbl,
    input logic             low_is_pos,
    input int               lo,
    input int               hi
  );
    logic signed [SW-1:0] mag;
    logic signed [SW-1:0] nxt;
    logic signed [SW-1:0] lo_s;
    logic signed [SW-1:0] hi_s;
    logic                 up;
    lo_s = SW'(lo);
    hi_s = SW'(hi);
    mag  = far ? SW'(STEP_FAR) : SW'(STEP_NEAR);
    if (dbl) mag = mag <<< 1;
    nxt  = $signed({2'b00, cur});
    up   = (side == SIDE_LOW) ? low_is_pos : !low_is_pos;
    if (side != SIDE_NONE) begin
      nxt = up ? (nxt + mag) : (nxt - mag);
`ifdef CURSOR_WRAP_EN
      if (nxt < lo_s)      nxt = hi_s;
      else if (nxt > hi_s) nxt = lo_s;
`else
      if (nxt < lo_s)      nxt = lo_s;
      else if (nxt > hi_s) nxt = hi_s;
`endif
    end
    return nxt[POS_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Tick edge detect
  // ---------------------------------------------------------------------------
  logic tick_q;
  logic ev;

  // Previous tick level; reset high so a tick already high at clr release is
  // not seen as an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) tick_q <= 1'b1;
    else     tick_q <= tick;
  end

  assign ev = tick & ~tick_q;

  // ---------------------------------------------------------------------------
  // Acceleration FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  side_t            side_x_q, side_x_d;
  side_t            side_y_q, side_y_d;
  side_t            sx, sy;
  logic             far_x, far_y;
  logic             rev;
  logic             dbl;

  assign sx    = side_of(joy_x);
  assign sy    = side_of(joy_y);
  assign far_x = is_far(joy_x);
  assign far_y = is_far(joy_y);

  // State register: FSM state, hold count and the sides seen on the last event.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      side_x_q <= SIDE_NONE;
      side_y_q <= SIDE_NONE;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      side_x_q <= side_x_d;
      side_y_q <= side_y_d;
    end
  end

  // Next-state logic: advances only on a tick event; recenter forces IDLE.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    side_x_d = side_x_q;
    side_y_d = side_y_q;
    rev      = 1'b0;
    dbl      = 1'b0;
    if (recenter) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      side_x_d = SIDE_NONE;
      side_y_d = SIDE_NONE;
    end else if (ev) begin
      side_x_d = sx;
      side_y_d = sy;
      if (sx == SIDE_NONE && sy == SIDE_NONE) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        rev = (sx != SIDE_NONE && side_x_q != SIDE_NONE && sx != side_x_q) ||
              (sy != SIDE_NONE && side_y_q != SIDE_NONE && sy != side_y_q);
        if (rev) begin
          state_d = ST_SLOW;
          count_d = CNT_W'(1);
        end else begin
          // The tick that reaches HOLD_TICKS still moves at 1x; only ticks
          // that start in FAST get the doubled step.
          dbl     = (state_q == ST_FAST);
          count_d = (count_q >= HOLD_V) ? HOLD_V : count_q + CNT_W'(1);
          state_d = (count_d == HOLD_V) ? ST_FAST : ST_SLOW;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Position datapath
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] dot_x_d, dot_y_d;

  // Output logic: next cursor position; x moves +ve on low samples, y -ve.
  always_comb begin
    dot_x_d = dot_x;
    dot_y_d = dot_y;
    if (recenter) begin
      dot_x_d = POS_W'(INIT_X);
      dot_y_d = POS_W'(INIT_Y);
    end else if (ev) begin
      dot_x_d = move_axis(dot_x, sx, far_x, dbl, 1'b1, X_MIN, X_MAX);
      dot_y_d = move_axis(dot_y, sy, far_y, dbl, 1'b0, Y_MIN, Y_MAX);
    end
  end

  // Output registers: position and the FAST indicator.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dot_x <= POS_W'(INIT_X);
      dot_y <= POS_W'(INIT_Y);
      fast  <= 1'b0;
    end else begin
      dot_x <= dot_x_d;
      dot_y <= dot_y_d;
      fast  <= (state_d == ST_FAST);
    end
  end

endmodule

// File: tb/tb_joy_cursor_accel.sv
// tb_joy_cursor_accel
//   Directed bench for joy_cursor_accel. Stimulus pushes hand-computed
//   expected outputs into a queue and signals the monitor, which pops and
//   compares against the DUT outputs.

module tb_joy_cursor_accel;

  logic       clk;
  logic       clr;
  logic       tick;
  logic [9:0] joy_x;
  logic [9:0] joy_y;
  logic       recenter;
  logic [9:0] dot_x;
  logic [9:0] dot_y;
  logic       fast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;

  joy_cursor_accel dut (
    .clk      (clk),
    .clr      (clr),
    .tick     (tick),
    .joy_x    (joy_x),
    .joy_y    (joy_y),
    .recenter (recenter),
    .dot_x    (dot_x),
    .dot_y    (dot_y),
    .fast     (fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation when the stimulus says the
  // DUT outputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dot_x !== e.x || dot_y !== e.y || fast !== e.f) begin
          errors++;
          $display("FAIL %s: got x=%0d y=%0d fast=%0b, expected x=%0d y=%0d fast=%0b",
                   e.name, dot_x, dot_y, fast, e.x, e.y, e.f);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int x, input int y, input bit f);
    exp_t e;
    e.name = name;
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.f    = f;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  // One tick rising edge; returns on the negedge after the updating posedge.
  task automatic pulse_tick();
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_recenter();
    @(negedge clk) recenter = 1'b1;
    @(negedge clk) recenter = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int xs[10];
  int fs[10];

  initial begin
    clr      = 1'b1;
    tick     = 1'b1;
    joy_x    = 10'd512;
    joy_y    = 10'd512;
    recenter = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // 1: reset state; tick high at release, x pushed, no edge -> no move
    expect_out("reset", 234, 271, 1'b0);
    joy_x = 10'd100;
    repeat (4) @(negedge clk);
    expect_out("no_edge_hold", 234, 271, 1'b0);

    // 2: one far-right step, then deadzone tick, then idle cycles
    pulse_tick();
    expect_out("far_right", 254, 271, 1'b0);
    joy_x = 10'd512;
    pulse_tick();
    expect_out("deadzone", 254, 271, 1'b0);
    repeat (3) @(negedge clk);
    expect_out("between_ticks", 254, 271, 1'b0);

    do_recenter();
    expect_out("recenter1", 234, 271, 1'b0);

    // 3: diagonal far left/up, then reverse to far right until the right bound
`ifdef CURSOR_WRAP_EN
    xs = '{362, 239, 259, 279, 299, 319, 339, 359, 239, 279};
`else
    xs = '{239, 259, 279, 299, 319, 339, 359, 362, 362, 362};
`endif
    fs = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    joy_x = 10'd900;
    joy_y = 10'd100;
    pulse_tick();
    expect_out("diag_x_lo_bound", xs[0], 251, fs[0] != 0);
    joy_y = 10'd512;
    joy_x = 10'd100;
    for (int i = 1; i < 10; i++) begin
      pulse_tick();
      expect_out($sformatf("right_run_%0d", i), xs[i], 251, fs[i] != 0);
    end

    joy_x = 10'd512;
    do_recenter();
    expect_out("recenter2", 234, 271, 1'b0);

    // 4: hold down (near) for 9 ticks, then reverse
    joy_y = 10'd700;
    for (int k = 1; k <= 8; k++) begin
      pulse_tick();
      expect_out($sformatf("hold_down_%0d", k), 234, 271 + 10 * k, k == 8);
    end
    pulse_tick();
    expect_out("fast_step", 234, 371, 1'b1);
    joy_y = 10'd300;
    pulse_tick();
    expect_out("reverse_up", 234, 361, 1'b0);
    joy_y = 10'd512;
    pulse_tick();
    expect_out("back_idle", 234, 361, 1'b0);

    // 5: recenter coincident with a tick edge wins
    joy_x = 10'd100;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) begin
      tick     = 1'b1;
      recenter = 1'b1;
    end
    @(negedge clk) recenter = 1'b0;
    expect_out("recenter_vs_tick", 234, 271, 1'b0);

    // 6: build up to FAST, then async clear between edges
    pulse_tick();
    expect_out("after_recenter_step", 254, 271, 1'b0);
    repeat (7) pulse_tick();
`ifdef CURSOR_WRAP_EN
    expect_out("fast_before_clr", 259, 271, 1'b1);
`else
    expect_out("fast_before_clr", 362, 271, 1'b1);
`endif
    @(negedge clk);
    #2 clr = 1'b1;
    #1 expect_out("async_clr", 234, 271, 1'b0);
    @(negedge clk) clr = 1'b0;
    @(negedge clk);
    expect_out("after_clr", 234, 271, 1'b0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
